// File: rtl/nes_controller_poller.sv
// NES controller poller: periodically requests a controller fetch, captures
// the returned snapshot, publishes the held buttons and converts per-button
// changes into press/release events queued in a small first-word-fall-through
// FIFO for a ready/valid consumer.
module nes_controller_poller #(
    parameter int NUM_CONTROLLERS = 4,
    parameter int POLL_PERIOD     = 16666,
    parameter int FIFO_DEPTH      = 8,
    localparam int CW = (NUM_CONTROLLERS > 1) ? $clog2(NUM_CONTROLLERS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable_i,
    output logic                         start_fetch_o,
    input  logic                         fetch_valid_i,
    input  logic [8*NUM_CONTROLLERS-1:0] fetch_data_LIST_i,
    output logic [8*NUM_CONTROLLERS-1:0] buttons_LIST_o,
    output logic                         event_valid_o,
    input  logic                         event_ready_i,
    output logic [CW-1:0]                event_controller_o,
    output logic [2:0]                   event_button_o,
    output logic                         event_pressed_o,
    output logic                         overflow_o,
    input  logic                         clear_overflow_i
);

    localparam int NBITS = 8 * NUM_CONTROLLERS;
    localparam int IDXW  = $clog2(NBITS);
    localparam int PCW   = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int EW    = CW + 4;

    localparam logic [PCW-1:0]  PERIOD_LAST = PCW'(POLL_PERIOD - 1);
    localparam logic [IDXW-1:0] SCAN_LAST   = IDXW'(NBITS - 1);
    localparam logic [PW:0]     DEPTH_C     = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE, SCAN} state_t;

    state_t            state_reg, state_next;
    logic [PCW-1:0]    period_cnt_reg;
    logic              pending_reg;
    logic [NBITS-1:0]  buttons_reg;
    logic [NBITS-1:0]  old_reg;
    logic [IDXW-1:0]   idx_reg;

    logic              tick;
    logic              capture;
    logic              scan_active;

    // Event FIFO storage and bookkeeping
    logic [EW-1:0]     fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [PW:0]       count_reg;
    logic              overflow_reg;

    logic [IDXW-1:0]   scan_pos;
    logic              push_valid;
    logic [EW-1:0]     push_data;
    logic              pop;
    logic              push_ok;

    assign tick = enable_i && (period_cnt_reg == PERIOD_LAST);

    // Free-running poll period counter, parked at zero while disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_cnt_reg <= '0;
        end else if (!enable_i || period_cnt_reg == PERIOD_LAST) begin
            period_cnt_reg <= '0;
        end else begin
            period_cnt_reg <= period_cnt_reg + 1'b1;
        end
    end

    // One-deep request flag: a tick arriving while one is already pending is absorbed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_reg <= 1'b0;
        end else if (!enable_i) begin
            pending_reg <= 1'b0;
        end else if (tick) begin
            pending_reg <= 1'b1;
        end else if (start_fetch_o) begin
            pending_reg <= 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic: request, wait for valid to drop, wait for it to return, scan
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (pending_reg && fetch_valid_i) state_next = BUSY;
            BUSY: if (!fetch_valid_i)               state_next = DONE;
            DONE: if (fetch_valid_i)                state_next = SCAN;
            SCAN: if (idx_reg == SCAN_LAST)         state_next = IDLE;
            default:                                state_next = IDLE;
        endcase
    end

    // FSM outputs: fetch strobe, snapshot capture and scan enable
    always_comb begin
        start_fetch_o = 1'b0;
        capture       = 1'b0;
        scan_active   = 1'b0;
        case (state_reg)
            IDLE:    start_fetch_o = pending_reg && fetch_valid_i;
            DONE:    capture       = fetch_valid_i;
            SCAN:    scan_active   = 1'b1;
            default: ;
        endcase
    end

    // Snapshot capture keeps the previous snapshot for edge detection during the scan
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buttons_reg <= '0;
            old_reg     <= '0;
            idx_reg     <= '0;
        end else if (capture) begin
            buttons_reg <= fetch_data_LIST_i;
            old_reg     <= buttons_reg;
            idx_reg     <= '0;
        end else if (scan_active) begin
            idx_reg     <= idx_reg + 1'b1;
        end
    end

    // Scan walks each byte from bit 7 down to bit 0; flipping the low three index bits does that
    assign scan_pos   = idx_reg ^ IDXW'(7);
    assign push_valid = scan_active && (buttons_reg[scan_pos] != old_reg[scan_pos]);
    assign push_data  = {CW'(idx_reg >> 3), scan_pos[2:0], buttons_reg[scan_pos]};

    // A full FIFO still accepts a push when the head is popped in the same cycle
    assign pop     = event_ready_i && (count_reg != '0);
    assign push_ok = push_valid && ((count_reg < DEPTH_C) || pop);

    // FIFO storage write port
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_reg] <= push_data;
        end
    end

    // FIFO pointers, occupancy and sticky overflow (a drop beats a clear in the same cycle)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (push_valid && !push_ok) begin
                overflow_reg <= 1'b1;
            end else if (clear_overflow_i) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    assign buttons_LIST_o = buttons_reg;
    assign event_valid_o  = (count_reg != '0);
    assign overflow_o     = overflow_reg;
    assign {event_controller_o, event_button_o, event_pressed_o} = fifo_mem[rd_ptr_reg];

endmodule

// File: tb/tb_nes_controller_poller.sv
// Bench for nes_controller_poller with a behavioural controller interface model.
module tb_nes_controller_poller;

    localparam int NC = 4;
    localparam int PP = 64;
    localparam int FD = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        start_fetch;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic [31:0] buttons;
    logic        event_valid;
    logic        event_ready;
    logic [1:0]  event_controller;
    logic [2:0]  event_button;
    logic        event_pressed;
    logic        overflow;
    logic        clear_overflow;

    nes_controller_poller #(
        .NUM_CONTROLLERS(NC),
        .POLL_PERIOD(PP),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable_i(enable),
        .start_fetch_o(start_fetch),
        .fetch_valid_i(fetch_valid),
        .fetch_data_LIST_i(fetch_data),
        .buttons_LIST_o(buttons),
        .event_valid_o(event_valid),
        .event_ready_i(event_ready),
        .event_controller_o(event_controller),
        .event_button_o(event_button),
        .event_pressed_o(event_pressed),
        .overflow_o(overflow),
        .clear_overflow_i(clear_overflow)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int busy_len = 12;
    logic [31:0] model_data = 32'h0;

    int pulse_q[$];
    logic [5:0] ev_q[$];
    int run_len = 0;
    int max_run = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Interface model: drop valid the cycle after a request, raise it with data busy_len cycles later
    always begin
        @(negedge clk);
        if (start_fetch) begin
            @(posedge clk);
            #1 fetch_valid = 1'b0;
            repeat (busy_len) @(posedge clk);
            #1 fetch_data = model_data;
            fetch_valid = 1'b1;
        end
    end

    // Monitor: record request pulses, their width, and every event handed to the consumer
    always @(negedge clk) begin
        if (start_fetch) begin
            pulse_q.push_back(cyc);
            run_len = run_len + 1;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
        if (event_valid && event_ready)
            ev_q.push_back({event_controller, event_button, event_pressed});
    end

    function automatic logic [5:0] mk(input int c, input int b, input int p);
        logic [1:0] cc;
        logic [2:0] bb;
        cc = c[1:0];
        bb = b[2:0];
        return {cc, bb, p[0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pulse(output int pc);
        int n0;
        int k;
        n0 = pulse_q.size();
        k = 0;
        while (pulse_q.size() == n0 && k < 400) begin
            @(posedge clk);
            k++;
        end
        check("pulse_timeout", (k >= 400), 0);
        pc = (pulse_q.size() > 0) ? pulse_q[$] : 0;
    endtask

    task automatic wait_valid(input logic lvl);
        int k;
        k = 0;
        while (fetch_valid !== lvl && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("valid_timeout", (k >= 500), 0);
    endtask

    task automatic do_poll(input logic [31:0] d);
        int pc;
        model_data = d;
        wait_pulse(pc);
        repeat (55) @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] data;
        int          nev;
        logic [5:0]  ev [4];
    } vec_t;

    vec_t tv [7];

    task automatic set_vec(input int i, input logic [31:0] d, input int n,
                           input logic [5:0] e0, input logic [5:0] e1,
                           input logic [5:0] e2, input logic [5:0] e3);
        tv[i].data  = d;
        tv[i].nev   = n;
        tv[i].ev[0] = e0;
        tv[i].ev[1] = e1;
        tv[i].ev[2] = e2;
        tv[i].ev[3] = e3;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int pc;
        int s;
        int n_in;
        int pc_in;
        int n0;

        set_vec(0, 32'h0000_0081, 2, mk(0,7,1), mk(0,0,1), 6'h0, 6'h0);
        set_vec(1, 32'h0000_0001, 1, mk(0,7,0), 6'h0, 6'h0, 6'h0);
        set_vec(2, 32'h1000_0001, 1, mk(3,4,1), 6'h0, 6'h0, 6'h0);
        set_vec(3, 32'h1002_0001, 1, mk(2,1,1), 6'h0, 6'h0, 6'h0);
        set_vec(4, 32'h0002_0300, 4, mk(0,0,0), mk(1,1,1), mk(1,0,1), mk(3,4,0));
        set_vec(5, 32'h0002_0300, 0, 6'h0, 6'h0, 6'h0, 6'h0);
        set_vec(6, 32'h0000_0000, 3, mk(1,1,0), mk(1,0,0), mk(2,1,0), 6'h0);

        rst = 1'b1;
        enable = 1'b0;
        fetch_valid = 1'b1;
        fetch_data = 32'h0;
        event_ready = 1'b1;
        clear_overflow = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_start_fetch", start_fetch, 0);
        check("reset_buttons", buttons, 0);
        check("reset_event_valid", event_valid, 0);
        check("reset_overflow", overflow, 0);
        rst = 1'b0;
        step();
        enable = 1'b1;

        // Table: edge events per poll with the consumer always ready
        for (int i = 0; i < 7; i++) begin
            base = ev_q.size();
            do_poll(tv[i].data);
            check($sformatf("vec%0d_buttons", i), buttons, tv[i].data);
            check($sformatf("vec%0d_nevents", i), ev_q.size() - base, tv[i].nev);
            for (int j = 0; j < tv[i].nev; j++)
                check($sformatf("vec%0d_event%0d", i, j),
                      (base + j < ev_q.size()) ? ev_q[base + j] : 6'h3f, tv[i].ev[j]);
            $display("[TB] poll %0d data=%08h events=%0d", i, tv[i].data, ev_q.size() - base);
        end

        // Request pulses arrive exactly one poll period apart
        for (int i = 0; i < 6; i++)
            check($sformatf("period_%0d", i), pulse_q[i+1] - pulse_q[i], PP);

        // Overflow: consumer stalled, 32 presses against an 8-deep FIFO
        step();
        event_ready = 1'b0;
        base = ev_q.size();
        do_poll(32'hFFFF_FFFF);
        check("ovf_event_valid", event_valid, 1);
        check("ovf_flag", overflow, 1);
        check("ovf_buttons", buttons, 32'hFFFF_FFFF);
        step();
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        @(negedge clk);
        check("ovf_cleared", overflow, 0);
        step();
        event_ready = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("ovf_kept_count", ev_q.size() - base, 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("ovf_kept%0d", i),
                  (base + i < ev_q.size()) ? ev_q[base + i] : 6'h3f, mk(0, 7 - i, 1));
        check("ovf_drained", event_valid, 0);
        $display("[TB] overflow poll kept=%0d", ev_q.size() - base);
        do_poll(32'hFFFF_FFFF);

        // Full FIFO with simultaneous push and pop during the scan: nothing dropped
        step();
        event_ready = 1'b0;
        do_poll(32'h0000_0000);
        step();
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        base = ev_q.size();
        model_data = 32'hFFFF_FFFF;
        wait_pulse(pc);
        wait_valid(1'b0);
        wait_valid(1'b1);
        @(posedge clk);
        #1 event_ready = 1'b1;
        repeat (50) @(posedge clk);
        @(negedge clk);
        check("full_overflow", overflow, 0);
        check("full_total", ev_q.size() - base, 40);
        for (int i = 0; i < 8; i++)
            check($sformatf("full_old%0d", i),
                  (base + i < ev_q.size()) ? ev_q[base + i] : 6'h3f, mk(0, 7 - i, 0));
        check("full_first_new", (base + 8 < ev_q.size()) ? ev_q[base + 8] : 6'h3f, mk(0,7,1));
        check("full_last_new", (base + 39 < ev_q.size()) ? ev_q[base + 39] : 6'h3f, mk(3,0,1));
        check("full_drained", event_valid, 0);
        $display("[TB] full fifo poll events=%0d", ev_q.size() - base);

        // Long fetch spanning three periods: exactly one deferred request afterwards
        wait_pulse(pc);
        repeat (20) @(posedge clk);
        busy_len = 3 * PP;
        wait_pulse(s);
        repeat (5) @(posedge clk);
        busy_len = 12;
        repeat (245) @(posedge clk);
        @(negedge clk);
        n_in = 0;
        pc_in = 0;
        foreach (pulse_q[i])
            if (pulse_q[i] > s && pulse_q[i] <= s + 250) begin
                n_in++;
                pc_in = pulse_q[i];
            end
        check("long_pulse_count", n_in, 1);
        check("long_pulse_after", (pc_in > s + 3 * PP), 1);
        $display("[TB] long fetch start=%0d deferred=%0d", s, pc_in);

        // Reset in the middle of a scan
        step();
        event_ready = 1'b0;
        model_data = 32'h0F0F_0F0F;
        wait_pulse(pc);
        wait_valid(1'b0);
        wait_valid(1'b1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("scan_pre_buttons", buttons, 32'h0F0F_0F0F);
        check("scan_pre_event_valid", event_valid, 1);
        check("scan_pre_overflow", overflow, 1);
        rst = 1'b1;
        #1;
        check("scan_rst_start_fetch", start_fetch, 0);
        check("scan_rst_buttons", buttons, 0);
        check("scan_rst_event_valid", event_valid, 0);
        check("scan_rst_overflow", overflow, 0);
        $display("[TB] reset during scan");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset while waiting for the interface, then stay disabled
        wait_pulse(pc);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("busy_pre_valid_low", fetch_valid, 0);
        rst = 1'b1;
        #1;
        check("busy_rst_start_fetch", start_fetch, 0);
        check("busy_rst_buttons", buttons, 0);
        check("busy_rst_event_valid", event_valid, 0);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n0 = pulse_q.size();
        repeat (200) @(posedge clk);
        @(negedge clk);
        check("disabled_no_pulse", pulse_q.size() - n0, 0);
        check("disabled_buttons", buttons, 0);
        check("disabled_event_valid", event_valid, 0);
        $display("[TB] reset during fetch, disabled pulses=%0d", pulse_q.size() - n0);

        check("pulse_width", max_run, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
